// File: rtl/lookup_engine.sv
// Match-action lookup stage: 16-entry ternary table held in registers, searched by a
// 3-stage pipeline (capture, compare, resolve), with saturating hit/miss statistics.
module lookup_engine #(
    parameter int KEY_LEN = 896,
    parameter int PHV_LEN = 1579,
    parameter int ACT_LEN = 625
) (
    input  logic               axis_clk,
    input  logic               areset,
    input  logic               key_valid,
    input  logic [KEY_LEN-1:0] extract_key,
    input  logic [KEY_LEN-1:0] key_mask,
    input  logic               cond_flag,
    input  logic [PHV_LEN-1:0] pkt_hdr_vec,
    input  logic               cfg_wr_en,
    input  logic [3:0]         cfg_addr,
    input  logic               cfg_entry_valid,
    input  logic [KEY_LEN-1:0] cfg_key,
    input  logic [KEY_LEN-1:0] cfg_mask,
    input  logic [ACT_LEN-1:0] cfg_action,
    output logic               action_valid,
    output logic [ACT_LEN-1:0] action_out,
    output logic               hit,
    output logic [3:0]         hit_idx,
    output logic [PHV_LEN-1:0] pkt_hdr_vec_out,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int          DEPTH   = 16;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [DEPTH-1:0]   entryValid_q, entryValid_d;
    logic [KEY_LEN-1:0] entryKey_q  [DEPTH];
    logic [KEY_LEN-1:0] entryMask_q [DEPTH];
    logic [ACT_LEN-1:0] entryAct_q  [DEPTH];

    logic [DEPTH-1:0]   wrSel;
    logic [KEY_LEN-1:0] fwdKey  [DEPTH];
    logic [KEY_LEN-1:0] fwdMask [DEPTH];
    logic [ACT_LEN-1:0] fwdAct  [DEPTH];

    logic               s1Valid_q;
    logic [KEY_LEN-1:0] s1Key_q, s1KeyMask_q;
    logic               s1Cond_q;
    logic [PHV_LEN-1:0] s1Phv_q;

    logic [DEPTH-1:0]   matchVec;
    logic               s2Valid_q;
    logic [DEPTH-1:0]   s2Match_q;
    logic [PHV_LEN-1:0] s2Phv_q;

    logic               resHit;
    logic [3:0]         resIdx;
    logic [ACT_LEN-1:0] resAct;

    logic               actValid_q, actValid_d;
    logic [ACT_LEN-1:0] actOut_q, actOut_d;
    logic               hit_q, hit_d;
    logic [3:0]         hitIdx_q, hitIdx_d;
    logic [PHV_LEN-1:0] phvOut_q, phvOut_d;
    logic [31:0]        hitCnt_q, hitCnt_d;
    logic [31:0]        missCnt_q, missCnt_d;

    // A write landing on the same edge as a compare or resolve is forwarded, so the
    // stage moving through that edge already sees the new entry contents.
    always_comb begin
        wrSel        = '0;
        entryValid_d = entryValid_q;
        if (cfg_wr_en) begin
            wrSel[cfg_addr] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwdKey[i]  = entryKey_q[i];
            fwdMask[i] = entryMask_q[i];
            fwdAct[i]  = entryAct_q[i];
            if (wrSel[i]) begin
                entryValid_d[i] = cfg_entry_valid;
                fwdKey[i]       = cfg_key;
                fwdMask[i]      = cfg_mask;
                fwdAct[i]       = cfg_action;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (cfg_wr_en) begin
            entryKey_q[cfg_addr]  <= cfg_key;
            entryMask_q[cfg_addr] <= cfg_mask;
            entryAct_q[cfg_addr]  <= cfg_action;
        end
    end

    always_comb begin
        matchVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            matchVec[i] = entryValid_d[i] & s1Cond_q &
                          ~|((s1Key_q ^ fwdKey[i]) & fwdMask[i] & s1KeyMask_q);
        end
    end

    // Pipeline payload carries no reset; only the valid bits qualify it.
    always_ff @(posedge axis_clk) begin
        if (key_valid) begin
            s1Key_q     <= extract_key;
            s1KeyMask_q <= key_mask;
            s1Cond_q    <= cond_flag;
            s1Phv_q     <= pkt_hdr_vec;
        end
        if (s1Valid_q) begin
            s2Match_q <= matchVec;
            s2Phv_q   <= s1Phv_q;
        end
    end

    // Lowest set index wins, so scan from the top down and let lower hits overwrite.
    always_comb begin
        resIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s2Match_q[i]) begin
                resIdx = 4'(i);
            end
        end
        resHit = |s2Match_q;
        resAct = resHit ? fwdAct[resIdx] : '0;
    end

    always_comb begin
        actValid_d = s2Valid_q;
        actOut_d   = actOut_q;
        hit_d      = hit_q;
        hitIdx_d   = hitIdx_q;
        phvOut_d   = phvOut_q;
        hitCnt_d   = hitCnt_q;
        missCnt_d  = missCnt_q;
        if (s2Valid_q) begin
            actOut_d = resAct;
            hit_d    = resHit;
            hitIdx_d = resIdx;
            phvOut_d = s2Phv_q;
            if (resHit) begin
                if (hitCnt_q != CNT_MAX) begin
                    hitCnt_d = hitCnt_q + 32'd1;
                end
            end else if (missCnt_q != CNT_MAX) begin
                missCnt_d = missCnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            entryValid_q <= '0;
            s1Valid_q    <= 1'b0;
            s2Valid_q    <= 1'b0;
            actValid_q   <= 1'b0;
            actOut_q     <= '0;
            hit_q        <= 1'b0;
            hitIdx_q     <= '0;
            phvOut_q     <= '0;
            hitCnt_q     <= '0;
            missCnt_q    <= '0;
        end else begin
            entryValid_q <= entryValid_d;
            s1Valid_q    <= key_valid;
            s2Valid_q    <= s1Valid_q;
            actValid_q   <= actValid_d;
            actOut_q     <= actOut_d;
            hit_q        <= hit_d;
            hitIdx_q     <= hitIdx_d;
            phvOut_q     <= phvOut_d;
            hitCnt_q     <= hitCnt_d;
            missCnt_q    <= missCnt_d;
        end
    end

    assign action_valid    = actValid_q;
    assign action_out      = actOut_q;
    assign hit             = hit_q;
    assign hit_idx         = hitIdx_q;
    assign pkt_hdr_vec_out = phvOut_q;
    assign hit_cnt         = hitCnt_q;
    assign miss_cnt        = missCnt_q;

endmodule

// File: tb/tb_lookup_engine.sv
// Self-checking bench for lookup_engine: directed scenarios plus randomized traffic,
// checked every cycle against an edge-level behavioural model of the table and stages.
module tb_lookup_engine;
    localparam int KEY_LEN = 896;
    localparam int PHV_LEN = 1579;
    localparam int ACT_LEN = 625;
    localparam int W       = 2048;

    logic               axis_clk;
    logic               areset;
    logic               key_valid;
    logic [KEY_LEN-1:0] extract_key;
    logic [KEY_LEN-1:0] key_mask;
    logic               cond_flag;
    logic [PHV_LEN-1:0] pkt_hdr_vec;
    logic               cfg_wr_en;
    logic [3:0]         cfg_addr;
    logic               cfg_entry_valid;
    logic [KEY_LEN-1:0] cfg_key;
    logic [KEY_LEN-1:0] cfg_mask;
    logic [ACT_LEN-1:0] cfg_action;
    logic               action_valid;
    logic [ACT_LEN-1:0] action_out;
    logic               hit;
    logic [3:0]         hit_idx;
    logic [PHV_LEN-1:0] pkt_hdr_vec_out;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    int checkCount = 0;
    int errorCount = 0;

    lookup_engine #(
        .KEY_LEN(KEY_LEN),
        .PHV_LEN(PHV_LEN),
        .ACT_LEN(ACT_LEN)
    ) dut (
        .axis_clk       (axis_clk),
        .areset         (areset),
        .key_valid      (key_valid),
        .extract_key    (extract_key),
        .key_mask       (key_mask),
        .cond_flag      (cond_flag),
        .pkt_hdr_vec    (pkt_hdr_vec),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_addr       (cfg_addr),
        .cfg_entry_valid(cfg_entry_valid),
        .cfg_key        (cfg_key),
        .cfg_mask       (cfg_mask),
        .cfg_action     (cfg_action),
        .action_valid   (action_valid),
        .action_out     (action_out),
        .hit            (hit),
        .hit_idx        (hit_idx),
        .pkt_hdr_vec_out(pkt_hdr_vec_out),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h (low 64 bits) at %0t",
                     tag, observed[63:0], expected[63:0], $time);
        end
    endtask

    function automatic logic [W-1:0] randWide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [KEY_LEN-1:0] randKey();
        logic [W-1:0] r;
        r = randWide();
        return r[KEY_LEN-1:0];
    endfunction

    function automatic logic [PHV_LEN-1:0] randPhv();
        logic [W-1:0] r;
        r = randWide();
        return r[PHV_LEN-1:0];
    endfunction

    function automatic logic [ACT_LEN-1:0] randAct();
        logic [W-1:0] r;
        r = randWide();
        return r[ACT_LEN-1:0];
    endfunction

    // Behavioural model: table contents as arrays, plus what each stage holds.
    logic               mValid [16];
    logic [KEY_LEN-1:0] mKey   [16];
    logic [KEY_LEN-1:0] mMask  [16];
    logic [ACT_LEN-1:0] mAct   [16];
    logic               m1Valid = 1'b0;
    logic               m1Cond  = 1'b0;
    logic [KEY_LEN-1:0] m1Key, m1KeyMask;
    logic [PHV_LEN-1:0] m1Phv;
    logic               m2Valid = 1'b0;
    logic               m2Hit   = 1'b0;
    logic [3:0]         m2Idx   = '0;
    logic [PHV_LEN-1:0] m2Phv;
    logic               expValid = 1'b0;
    logic               expHit   = 1'b0;
    logic [3:0]         expIdx   = '0;
    logic [ACT_LEN-1:0] expAct   = '0;
    logic [PHV_LEN-1:0] expPhv   = '0;
    logic [31:0]        mHit     = '0;
    logic [31:0]        mMiss    = '0;

    task automatic refLookup(input logic [KEY_LEN-1:0] key, input logic [KEY_LEN-1:0] kmask,
                             input logic cond, output logic h, output logic [3:0] idx);
        h   = 1'b0;
        idx = 4'd0;
        if (cond) begin
            for (int i = 0; i < 16; i++) begin
                if (!h && mValid[i] && (((key ^ mKey[i]) & mMask[i] & kmask) == '0)) begin
                    h   = 1'b1;
                    idx = 4'(i);
                end
            end
        end
    endtask

    // Order within one edge: the write lands first, then resolve and compare see it.
    task automatic modelStep();
        logic       h;
        logic [3:0] idx;
        if (areset) begin
            for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
            m1Valid  = 1'b0;
            m2Valid  = 1'b0;
            expValid = 1'b0;
            expHit   = 1'b0;
            expIdx   = '0;
            expAct   = '0;
            expPhv   = '0;
            mHit     = '0;
            mMiss    = '0;
        end else begin
            if (cfg_wr_en) begin
                mValid[cfg_addr] = cfg_entry_valid;
                mKey[cfg_addr]   = cfg_key;
                mMask[cfg_addr]  = cfg_mask;
                mAct[cfg_addr]   = cfg_action;
            end
            expValid = m2Valid;
            if (m2Valid) begin
                expHit = m2Hit;
                expIdx = m2Idx;
                expAct = m2Hit ? mAct[m2Idx] : '0;
                expPhv = m2Phv;
                if (m2Hit) begin
                    if (mHit != 32'hFFFF_FFFF) mHit = mHit + 32'd1;
                end else if (mMiss != 32'hFFFF_FFFF) begin
                    mMiss = mMiss + 32'd1;
                end
            end
            m2Valid = m1Valid;
            if (m1Valid) begin
                refLookup(m1Key, m1KeyMask, m1Cond, h, idx);
                m2Hit = h;
                m2Idx = idx;
                m2Phv = m1Phv;
            end
            m1Valid = key_valid;
            if (key_valid) begin
                m1Key     = extract_key;
                m1KeyMask = key_mask;
                m1Cond    = cond_flag;
                m1Phv     = pkt_hdr_vec;
            end
        end
    endtask

    initial forever begin
        @(posedge axis_clk or posedge areset);
        modelStep();
    end

    // Every cycle, all outputs must agree with the model (including hold behaviour).
    initial forever begin
        @(negedge axis_clk);
        checkOutput("mon action_valid", W'(action_valid), W'(expValid));
        checkOutput("mon hit", W'(hit), W'(expHit));
        checkOutput("mon hit_idx", W'(hit_idx), W'(expIdx));
        checkOutput("mon action_out", W'(action_out), W'(expAct));
        checkOutput("mon pkt_hdr_vec_out", W'(pkt_hdr_vec_out), W'(expPhv));
        checkOutput("mon hit_cnt", W'(hit_cnt), W'(mHit));
        checkOutput("mon miss_cnt", W'(miss_cnt), W'(mMiss));
    end

    task automatic setKey(input logic [KEY_LEN-1:0] key, input logic [KEY_LEN-1:0] kmask,
                          input logic cond, input logic [PHV_LEN-1:0] phv);
        key_valid   = 1'b1;
        extract_key = key;
        key_mask    = kmask;
        cond_flag   = cond;
        pkt_hdr_vec = phv;
    endtask

    task automatic setWrite(input logic [3:0] addr, input logic v, input logic [KEY_LEN-1:0] ek,
                            input logic [KEY_LEN-1:0] em, input logic [ACT_LEN-1:0] act);
        cfg_wr_en       = 1'b1;
        cfg_addr        = addr;
        cfg_entry_valid = v;
        cfg_key         = ek;
        cfg_mask        = em;
        cfg_action      = act;
    endtask

    // Holds the staged inputs across one rising edge, then drops the strobes.
    task automatic applyStimulus();
        @(negedge axis_clk);
        key_valid = 1'b0;
        cfg_wr_en = 1'b0;
    endtask

    task automatic waitResult(input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge axis_clk);
            n++;
        end while (!action_valid && n < maxCycles);
        checkOutput("result arrives", W'(action_valid), W'(1'b1));
    endtask

    initial begin
        logic [KEY_LEN-1:0] ones, kA, k2, k3, k4, kTmp, mTmp, rk, rm;
        logic [ACT_LEN-1:0] actA, act2, act5, act7, act9a, act9b;
        logic [PHV_LEN-1:0] phv;
        logic [KEY_LEN-1:0] pool [4];

        ones = '1;
        areset = 1'b1;
        key_valid = 1'b0; extract_key = '0; key_mask = '0; cond_flag = 1'b0; pkt_hdr_vec = '0;
        cfg_wr_en = 1'b0; cfg_addr = '0; cfg_entry_valid = 1'b0;
        cfg_key = '0; cfg_mask = '0; cfg_action = '0;
        repeat (3) @(negedge axis_clk);
        #1 areset = 1'b0;
        @(negedge axis_clk);
        checkOutput("reset action_valid", W'(action_valid), W'(1'b0));
        checkOutput("reset hit_idx", W'(hit_idx), W'(4'd0));
        checkOutput("reset action_out", W'(action_out), W'(1'b0));
        checkOutput("reset phv_out", W'(pkt_hdr_vec_out), W'(1'b0));
        checkOutput("reset hit_cnt", W'(hit_cnt), W'(32'd0));
        checkOutput("reset miss_cnt", W'(miss_cnt), W'(32'd0));

        $display("[TB] basic hit on entry 3");
        kA = randKey(); actA = randAct(); phv = randPhv();
        setWrite(4'd3, 1'b1, kA, ones, actA); applyStimulus();
        setKey(kA, ones, 1'b1, phv); applyStimulus();
        waitResult(5);
        checkOutput("t1 hit", W'(hit), W'(1'b1));
        checkOutput("t1 hit_idx", W'(hit_idx), W'(4'd3));
        checkOutput("t1 action_out", W'(action_out), W'(actA));
        checkOutput("t1 phv_out", W'(pkt_hdr_vec_out), W'(phv));
        checkOutput("t1 hit_cnt", W'(hit_cnt), W'(32'd1));

        $display("[TB] priority between entries 2 and 5");
        k2 = randKey(); act2 = randAct(); act5 = randAct();
        setWrite(4'd2, 1'b1, k2, ones, act2); applyStimulus();
        setWrite(4'd5, 1'b1, k2, ones, act5); applyStimulus();
        setKey(k2, ones, 1'b1, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t2 hit_idx low", W'(hit_idx), W'(4'd2));
        checkOutput("t2 action low", W'(action_out), W'(act2));
        setWrite(4'd2, 1'b0, k2, ones, act2); applyStimulus();
        setKey(k2, ones, 1'b1, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t2 hit_idx after invalidate", W'(hit_idx), W'(4'd5));
        checkOutput("t2 action after invalidate", W'(action_out), W'(act5));

        $display("[TB] cond_flag forces a miss");
        setKey(k2, ones, 1'b0, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t3 hit", W'(hit), W'(1'b0));
        checkOutput("t3 hit_idx", W'(hit_idx), W'(4'd0));
        checkOutput("t3 action_out", W'(action_out), W'(1'b0));
        checkOutput("t3 miss_cnt", W'(miss_cnt), W'(32'd1));

        $display("[TB] per-packet key mask on bit 0");
        k3 = randKey(); act7 = randAct();
        setWrite(4'd7, 1'b1, k3, ones, act7); applyStimulus();
        kTmp = k3; kTmp[0] = ~kTmp[0];
        mTmp = ones; mTmp[0] = 1'b0;
        setKey(kTmp, mTmp, 1'b1, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t4 masked hit", W'(hit), W'(1'b1));
        checkOutput("t4 masked hit_idx", W'(hit_idx), W'(4'd7));
        setKey(kTmp, ones, 1'b1, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t4 unmasked miss", W'(hit), W'(1'b0));

        $display("[TB] ten back-to-back lookups");
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) setKey(kA, ones, 1'b1, randPhv());
            else            setKey(randKey(), ones, 1'b1, randPhv());
            applyStimulus();
        end
        repeat (2) @(negedge axis_clk);
        checkOutput("t5 last valid", W'(action_valid), W'(1'b1));
        checkOutput("t5 last is miss", W'(hit), W'(1'b0));
        checkOutput("t5 hit_cnt", W'(hit_cnt), W'(32'd9));
        checkOutput("t5 miss_cnt", W'(miss_cnt), W'(32'd7));
        @(negedge axis_clk);
        checkOutput("t5 valid drops", W'(action_valid), W'(1'b0));

        $display("[TB] zero effective mask");
        setKey(randKey(), '0, 1'b1, randPhv()); applyStimulus();
        waitResult(5);
        checkOutput("t6 hit_idx", W'(hit_idx), W'(4'd3));
        checkOutput("t6 action_out", W'(action_out), W'(actA));

        $display("[TB] write/lookup collision");
        k4 = randKey(); act9a = randAct(); act9b = randAct();
        setKey(k4, ones, 1'b1, randPhv()); applyStimulus();
        setWrite(4'd9, 1'b1, k4, ones, act9a); applyStimulus();
        setWrite(4'd9, 1'b1, k4, ones, act9b); applyStimulus();
        checkOutput("t7 valid", W'(action_valid), W'(1'b1));
        checkOutput("t7 hit_idx", W'(hit_idx), W'(4'd9));
        checkOutput("t7 action_out", W'(action_out), W'(act9b));

        $display("[TB] miss counter saturation");
        repeat (3) @(negedge axis_clk);
        #1;
        force dut.missCnt_q = 32'hFFFF_FFFE;
        mMiss = 32'hFFFF_FFFE;
        @(negedge axis_clk);
        #1;
        release dut.missCnt_q;
        for (int i = 0; i < 3; i++) begin
            setKey(kA, ones, 1'b0, randPhv());
            applyStimulus();
        end
        repeat (2) @(negedge axis_clk);
        checkOutput("t8 miss_cnt saturated", W'(miss_cnt), W'(32'hFFFF_FFFF));

        $display("[TB] reset with lookups in flight");
        setKey(kA, ones, 1'b1, randPhv()); applyStimulus();
        setKey(kA, ones, 1'b1, randPhv()); applyStimulus();
        #1 areset = 1'b1;
        repeat (2) @(negedge axis_clk);
        #1 areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge axis_clk);
            checkOutput("t9 no valid after reset", W'(action_valid), W'(1'b0));
        end
        checkOutput("t9 hit_cnt", W'(hit_cnt), W'(32'd0));
        checkOutput("t9 miss_cnt", W'(miss_cnt), W'(32'd0));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4; i++) pool[i] = randKey();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    0:       rm = '0;
                    1, 2:    rm = randKey();
                    default: rm = ones;
                endcase
                setWrite(4'($urandom_range(0, 15)), ($urandom_range(0, 5) != 0),
                         pool[$urandom_range(0, 3)], rm, randAct());
            end
            if ($urandom_range(0, 3) != 0) begin
                rk = pool[$urandom_range(0, 3)];
                if ($urandom_range(0, 3) == 0) rk[$urandom_range(0, KEY_LEN - 1)] ^= 1'b1;
                case ($urandom_range(0, 15))
                    0:          rm = '0;
                    1, 2, 3:    rm = randKey();
                    default:    rm = ones;
                endcase
                setKey(rk, rm, ($urandom_range(0, 7) != 0), randPhv());
            end
            applyStimulus();
        end
        repeat (5) @(negedge axis_clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
